// File: rtl/seq_101_gen_if.sv
// Handshake and serial-output bundle for seq_101_gen.
// SEQ_GEN_MATCH_CNT_EN adds the match_cnt signal.
interface seq_101_gen_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REP_W = 4,
  parameter int unsigned CNT_W = 8
) ();
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [REP_W-1:0] rep_in;
  logic             abort;
  logic             ready;
  logic             x;
  logic             x_valid;
  logic             done;
`ifdef SEQ_GEN_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output start, data_in, rep_in, abort,
    input  ready, x, x_valid, done, match_cnt
  );

  modport slave (
    input  start, data_in, rep_in, abort,
    output ready, x, x_valid, done, match_cnt
  );
`else
  modport master (
    output start, data_in, rep_in, abort,
    input  ready, x, x_valid, done
  );

  modport slave (
    input  start, data_in, rep_in, abort,
    output ready, x, x_valid, done
  );
`endif
endinterface

// File: rtl/seq_101_gen.sv
// Serial pattern transmitter: shifts a latched word out MSB-first, rep_in+1 times, then pulses done.
// Define SEQ_GEN_MATCH_CNT_EN to add a saturating count of overlapping "101" in the sent bits.
module seq_101_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REP_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic          clk,
  input logic          reset_n,
  seq_101_gen_if.slave bus
);

  localparam int unsigned BitW = $clog2(WIDTH);
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("seq_101_gen: WIDTH must be in 2..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_101_gen: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      word_q    <= '0;
      bit_cnt_q <= '0;
      rep_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      bit_cnt_q <= bit_cnt_d;
      rep_q     <= rep_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    word_d    = word_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          shift_d   = bus.data_in;
          word_d    = bus.data_in;
          rep_d     = bus.rep_in;
          bit_cnt_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (bit_cnt_q == LastBit) begin
          // Reload from the latched copy so repeats ignore later data_in changes.
          if (rep_q != '0) begin
            shift_d   = word_q;
            rep_d     = rep_q - REP_W'(1);
            bit_cnt_d = '0;
          end else begin
            state_d = StDone;
          end
        end else begin
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BitW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.ready   = (state_q == StIdle);
  assign bus.x_valid = (state_q == StShift);
  assign bus.x       = (state_q == StShift) & shift_q[WIDTH-1];
  assign bus.done    = (state_q == StDone);

`ifdef SEQ_GEN_MATCH_CNT_EN
  logic [1:0]       hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    if (state_q == StIdle && bus.start) begin
      hist_d = '0;
      cnt_d  = '0;
    end else if (state_q == StShift) begin
      hist_d = {hist_q[0], shift_q[WIDTH-1]};
      if ({hist_q, shift_q[WIDTH-1]} == 3'b101 && cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_101_gen.sv
// Self-checking bench for seq_101_gen: expected serial bits are queued at send time and
// popped by a negedge monitor whenever x_valid is high.
module tb_seq_101_gen;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned REP_W = 4;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq_101_gen_if #(.WIDTH(WIDTH), .REP_W(REP_W), .CNT_W(CNT_W)) bus ();

  seq_101_gen #(.WIDTH(WIDTH), .REP_W(REP_W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  bit exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard consumer: every valid bit must match the next queued bit.
  always @(negedge clk) begin
    bit e;
    if (reset_n) begin
      if (bus.done) done_cnt++;
      if (bus.x_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("x_unexpected_qsize", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_eq("x_bit", bus.x, e);
        end
      end else begin
        check_eq("x_idle_zero", bus.x, 0);
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] d, input int rep);
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_before_send", bus.ready, 1);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.rep_in  = REP_W'(rep);
    for (int r = 0; r <= rep; r++) begin
      for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(d[i]);
    end
    valid_cnt = 0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check_eq("first_bit_latency", bus.x_valid, 1);
  endtask

  task automatic run_until_done(input int rep, input int exp_match, input bit poke);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
    end
    check_eq("done_seen", seen, 1);
    check_eq("bits_left", exp_q.size(), 0);
    check_eq("valid_cycles", valid_cnt, WIDTH * (rep + 1));
    check_eq("ready_in_done", bus.ready, 0);
    check_eq("x_valid_in_done", bus.x_valid, 0);
`ifdef SEQ_GEN_MATCH_CNT_EN
    check_eq("match_cnt", bus.match_cnt, exp_match);
`endif
    if (poke) begin
      // start during DONE must not be taken on the DONE->IDLE edge.
      bus.start   = 1'b1;
      bus.data_in = '0;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    @(negedge clk);
    check_eq("ready_after_done", bus.ready, 1);
    check_eq("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    int d0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.data_in = '0;
    bus.rep_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", bus.ready, 1);
    check_eq("rst_x_valid", bus.x_valid, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", bus.ready, 1);
    check_eq("post_rst_x", bus.x, 0);
    check_eq("post_rst_x_valid", bus.x_valid, 0);
    check_eq("post_rst_done", bus.done, 0);
`ifdef SEQ_GEN_MATCH_CNT_EN
    check_eq("post_rst_match", bus.match_cnt, 0);
`endif

    // Single word and back-to-back repeat.
    send(8'hAD, 0);
    run_until_done(0, 3, 1'b0);
    send(8'hAD, 1);
    run_until_done(1, 6, 1'b0);

    // Changing data_in mid-stream must not affect repeats.
    send(8'hAD, 2);
    repeat (3) @(negedge clk);
    bus.data_in = 8'h00;
    run_until_done(2, 9, 1'b0);

    // Abort sampled on the edge that ends the 4th valid bit.
    d0 = done_cnt;
    send(8'hFF, 0);
    repeat (3) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("abort_x_valid", bus.x_valid, 0);
    check_eq("abort_ready", bus.ready, 1);
    check_eq("abort_valid_cycles", valid_cnt, 4);
    repeat (3) @(negedge clk);
    check_eq("abort_no_done", done_cnt, d0);
    send(8'h05, 0);
    run_until_done(0, 1, 1'b0);

    // start pulses during SHIFT and DONE are ignored.
    send(8'hAD, 0);
    repeat (2) @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 8'h00;
    bus.rep_in  = REP_W'(3);
    @(posedge clk);
    #1 bus.start = 1'b0;
    d0 = done_cnt;
    run_until_done(0, 3, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("busy_single_done", done_cnt, d0 + 1);
    check_eq("busy_idle_ready", bus.ready, 1);

    // Asynchronous reset mid-stream.
    send(8'hAD, 1);
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_ready", bus.ready, 1);
    check_eq("async_rst_x", bus.x, 0);
    check_eq("async_rst_x_valid", bus.x_valid, 0);
    check_eq("async_rst_done", bus.done, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rst_no_done", done_cnt, d0);
    check_eq("rst_idle_ready", bus.ready, 1);
    check_eq("done_total", done_cnt, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
